// File: rtl/spi_master_arb.sv
// Two-requester SPI master: arbitrates req0/req1, then shifts a 14-bit LSB-first frame
// (addr[4:0], mode, data[7:0]). Define SPI_ARB_RR_EN for round-robin, else fixed priority to 0.
module spi_master_arb #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       mode0,
    input  logic       mode1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, GRANT, SHIFT, FINISH, GAP} state_t;

    state_t      state, state_nx;
    logic        owner;
    logic        winner;
    logic [13:0] shreg;
    logic [13:0] frame;
    logic        mode_q;
    logic [7:0]  div_cnt;
    logic [4:0]  edge_cnt;
    logic        sclk;
    logic [7:0]  rx;
    logic        div_last;
    logic        sel_mode;
    logic [4:0]  sel_addr;
    logic [7:0]  sel_wdata;

`ifdef SPI_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr names the requester that wins the next tie: the one not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (state == FINISH)
            rr_ptr <= ~owner;
    end

    assign winner = (req0 && req1) ? rr_ptr : ~req0;
`else
    assign winner = ~req0;
`endif

    assign sel_mode  = owner ? mode1  : mode0;
    assign sel_addr  = owner ? addr1  : addr0;
    assign sel_wdata = owner ? wdata1 : wdata0;
    // Reads put zeros on MOSI during the data phase.
    assign frame     = {sel_mode ? sel_wdata : 8'h00, sel_mode, sel_addr};
    assign div_last  = (div_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE:    if (req0 || req1) state_nx = GRANT;
            GRANT:   state_nx = SHIFT;
            SHIFT:   if (div_last && edge_cnt == 5'd27) state_nx = FINISH;
            FINISH:  state_nx = GAP;
            GAP:     if (div_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b0;
            shreg    <= 14'h0;
            mode_q   <= 1'b0;
            div_cnt  <= 8'h0;
            edge_cnt <= 5'h0;
            sclk     <= 1'b0;
            rx       <= 8'h0;
            rdata    <= 8'h0;
        end else begin
            div_cnt <= ((state == SHIFT || state == GAP) && !div_last) ? div_cnt + 8'd1 : 8'd0;
            unique case (state)
                IDLE: if (req0 || req1) owner <= winner;
                GRANT: begin
                    shreg    <= frame;
                    mode_q   <= frame[5];
                    edge_cnt <= 5'd0;
                    sclk     <= 1'b0;
                end
                SHIFT: if (div_last) begin
                    sclk     <= ~sclk;
                    edge_cnt <= edge_cnt + 5'd1;
                    if (!sclk) begin
                        // Rising edges 7..14 carry the read data.
                        if (edge_cnt >= 5'd12) rx <= {MISO, rx[7:1]};
                    end else begin
                        shreg <= {1'b0, shreg[13:1]};
                        if (edge_cnt == 5'd27 && !mode_q) rdata <= rx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Mid-frame reset drops CS straight away because CS decodes the state register.
    assign CS    = (state != SHIFT);
    assign SCLK  = sclk;
    assign MOSI  = shreg[0];
    assign gnt0  = (state == GRANT || state == SHIFT) && !owner;
    assign gnt1  = (state == GRANT || state == SHIFT) &&  owner;
    assign done0 = (state == FINISH) && !owner;
    assign done1 = (state == FINISH) &&  owner;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: write/read frames, tie arbitration, mid-frame reset,
// and inter-frame gap on a CLK_DIV=3 instance. Follows SPI_ARB_RR_EN for the tie order.
module tb_spi_master_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, mode0, mode1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata;
    logic       sclk, mosi, cs, miso;

    logic       req_3;
    logic       gnt0_3, gnt1_3, done0_3, done1_3;
    logic [7:0] rdata_3;
    logic       sclk_3, mosi_3, cs_3;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rise_total = 0;
    int          rise_base  = 0;
    int          done0_cnt  = 0;
    logic [63:0] mosi_hist  = '0;
    logic [13:0] slave_pat  = '0;
    logic [31:0] rise_idx;

    always #5 clk = ~clk;

    spi_master_arb #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .SCLK(sclk), .MOSI(mosi), .CS(cs), .MISO(miso)
    );

    spi_master_arb #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .req0(req_3), .req1(1'b0), .mode0(1'b1), .mode1(1'b0),
        .addr0(5'h0A), .addr1(5'h00), .wdata0(8'h5A), .wdata1(8'h00),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3), .rdata(rdata_3),
        .SCLK(sclk_3), .MOSI(mosi_3), .CS(cs_3), .MISO(1'b0)
    );

    // Slave model: presents pattern bit k until the (k+1)th SCLK rise of the current frame.
    assign rise_idx = rise_total - rise_base;
    assign miso     = (rise_idx < 14) ? slave_pat[rise_idx[3:0]] : 1'b0;

    always @(posedge sclk) begin
        rise_total <= rise_total + 1;
        mosi_hist  <= {mosi_hist[62:0], mosi};
    end

    always @(negedge clk) if (done0) done0_cnt <= done0_cnt + 1;

    // Runs one frame on the CLK_DIV=2 instance and reports what was observed.
    task automatic do_frame(input bit who, input bit mode, input logic [4:0] addr,
                            input logic [7:0] wd, input logic [7:0] slave_byte,
                            output int lat, output bit tmo, output logic [1:0] gnt_first,
                            output logic [13:0] mosi_word, output int rises,
                            output logic [7:0] rd_at_done, output logic done_after);
        @(negedge clk);
        slave_pat = {slave_byte, 6'b0};
        rise_base = rise_total;
        if (who) begin req1 = 1'b1; mode1 = mode; addr1 = addr; wdata1 = wd; end
        else     begin req0 = 1'b1; mode0 = mode; addr0 = addr; wdata0 = wd; end
        lat = 0; tmo = 1'b1; gnt_first = 2'b00; rd_at_done = 8'h00;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) gnt_first = {gnt1, gnt0};
            if (who ? done1 : done0) begin
                lat = i; tmo = 1'b0; rd_at_done = rdata;
                break;
            end
        end
        mosi_word = mosi_hist[13:0];
        rises     = rise_total - rise_base;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        done_after = done0 | done1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cs !== 1'b1)       begin n_bad++; $display("FAIL reset_cs got %b want 1", cs); end
        n_cmp++; if (sclk !== 1'b0)     begin n_bad++; $display("FAIL reset_sclk got %b want 0", sclk); end
        n_cmp++; if (mosi !== 1'b0)     begin n_bad++; $display("FAIL reset_mosi got %b want 0", mosi); end
        n_cmp++; if ({gnt1, gnt0} !== 2'b00)   begin n_bad++; $display("FAIL reset_gnt got %b want 00", {gnt1, gnt0}); end
        n_cmp++; if ({done1, done0} !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", {done1, done0}); end
        n_cmp++; if (rdata !== 8'h00)   begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read;
        int lat, rises; bit tmo; logic [1:0] g; logic [13:0] mw; logic [7:0] rd; logic da;
        do_frame(1'b1, 1'b0, 5'h03, 8'hFF, 8'h3C, lat, tmo, g, mw, rises, rd, da);
        n_cmp++; if (tmo !== 1'b0)  begin n_bad++; $display("FAIL read_timeout got %b want 0", tmo); end
        n_cmp++; if (lat != 58)     begin n_bad++; $display("FAIL read_latency got %0d want 58", lat); end
        n_cmp++; if (g !== 2'b10)   begin n_bad++; $display("FAIL read_gnt got %b want 10", g); end
        n_cmp++; if (mw !== 14'b11000000000000) begin n_bad++; $display("FAIL read_mosi got %b want 11000000000000", mw); end
        n_cmp++; if (rises != 14)   begin n_bad++; $display("FAIL read_sclk_rises got %0d want 14", rises); end
        n_cmp++; if (rd !== 8'h3C)  begin n_bad++; $display("FAIL read_rdata got %h want 3c", rd); end
        n_cmp++; if (da !== 1'b0)   begin n_bad++; $display("FAIL read_done_width got %b want 0", da); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write;
        int lat, rises; bit tmo; logic [1:0] g; logic [13:0] mw; logic [7:0] rd; logic da;
        do_frame(1'b0, 1'b1, 5'h15, 8'hA5, 8'hFF, lat, tmo, g, mw, rises, rd, da);
        n_cmp++; if (tmo !== 1'b0)  begin n_bad++; $display("FAIL write_timeout got %b want 0", tmo); end
        n_cmp++; if (lat != 58)     begin n_bad++; $display("FAIL write_latency got %0d want 58", lat); end
        n_cmp++; if (g !== 2'b01)   begin n_bad++; $display("FAIL write_gnt got %b want 01", g); end
        n_cmp++; if (mw !== 14'b10101110100101) begin n_bad++; $display("FAIL write_mosi got %b want 10101110100101", mw); end
        n_cmp++; if (rises != 14)   begin n_bad++; $display("FAIL write_sclk_rises got %0d want 14", rises); end
        n_cmp++; if (rd !== 8'h3C)  begin n_bad++; $display("FAIL write_rdata_kept got %h want 3c", rd); end
        n_cmp++; if (da !== 1'b0)   begin n_bad++; $display("FAIL write_done_width got %b want 0", da); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_tie;
        logic [3:0] exp_win;
        logic       win;
        bit         seen;
`ifdef SPI_ARB_RR_EN
        exp_win = 4'b1010;
`else
        exp_win = 4'b0000;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode0 = 1'b1; addr0 = 5'h01; wdata0 = 8'h11;
        mode1 = 1'b1; addr1 = 5'h02; wdata1 = 8'h22;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            seen = 1'b0; win = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (gnt0 || gnt1) begin seen = 1'b1; win = gnt1; end
            end
            n_cmp++;
            if (!seen || win !== exp_win[f])
                begin n_bad++; $display("FAIL tie_grant_%0d got %b (seen %b) want %b", f, win, seen, exp_win[f]); end
            for (int i = 0; i < 100 && !(done0 || done1); i++) @(negedge clk);
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int lat, rises, base, dcnt; bit tmo; logic [1:0] g; logic [13:0] mw; logic [7:0] rd; logic da;
        @(negedge clk);
        base = rise_total;
        req0 = 1'b1; mode0 = 1'b1; addr0 = 5'h15; wdata0 = 8'hA5;
        for (int i = 0; i < 100 && (rise_total - base) < 5; i++) @(negedge clk);
        dcnt = done0_cnt;
        rst = 1'b1;
        #1;
        n_cmp++; if (cs !== 1'b1)   begin n_bad++; $display("FAIL midrst_cs got %b want 1", cs); end
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk got %b want 0", sclk); end
        n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL midrst_gnt0 got %b want 0", gnt0); end
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        rst  = 1'b0;
        repeat (70) @(negedge clk);
        n_cmp++; if (done0_cnt != dcnt) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", done0_cnt - dcnt); end
        do_frame(1'b0, 1'b1, 5'h15, 8'hA5, 8'h00, lat, tmo, g, mw, rises, rd, da);
        n_cmp++; if (lat != 58) begin n_bad++; $display("FAIL midrst_next_latency got %0d want 58", lat); end
        n_cmp++; if (mw !== 14'b10101110100101) begin n_bad++; $display("FAIL midrst_next_mosi got %b want 10101110100101", mw); end
        n_cmp++; if (rises != 14) begin n_bad++; $display("FAIL midrst_next_rises got %0d want 14", rises); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int frames, gap_len, min_gap, first_lat, onehot_bad;
        frames = 0; gap_len = 0; min_gap = 9999; first_lat = 0; onehot_bad = 0;
        @(negedge clk);
        req_3 = 1'b1;
        for (int i = 1; i <= 600 && frames < 3; i++) begin
            @(negedge clk);
            if (gnt0_3 && gnt1_3) onehot_bad++;
            if (frames >= 1) begin
                if (cs_3) gap_len++;
                else if (gap_len > 0) begin
                    if (gap_len < min_gap) min_gap = gap_len;
                    gap_len = 0;
                end
            end
            if (done0_3) begin
                if (frames == 0) first_lat = i;
                frames++;
                gap_len = 1;
            end
        end
        req_3 = 1'b0;
        n_cmp++; if (frames != 3)     begin n_bad++; $display("FAIL b2b_frames got %0d want 3", frames); end
        n_cmp++; if (first_lat != 86) begin n_bad++; $display("FAIL b2b_latency got %0d want 86", first_lat); end
        n_cmp++; if (min_gap < 3)     begin n_bad++; $display("FAIL b2b_cs_gap got %0d want >=3", min_gap); end
        n_cmp++; if (onehot_bad != 0) begin n_bad++; $display("FAIL b2b_onehot got %0d violations want 0", onehot_bad); end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req_3 = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_tie;
        test_reset_midframe;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
